// File: rtl/ram_1r1w_synch_param.sv
// Single-clock 1R1W RAM with synchronous read and registered read-valid.
// After reset release it can zero the whole array before accepting traffic.
// It also has an optional write-first bypass, an optional extra output
// stage, and detection of out-of-range addresses for non-power-of-two depths.
module ram_1r1w_synch_param #(
    parameter int unsigned DATA_W        = 4,
    parameter int unsigned ADDR_W        = 3,
    parameter int unsigned DEPTH         = 8,
    parameter bit          OUT_REG       = 1'b0,
    parameter bit          BYPASS        = 1'b1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_wr,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_din,
    input  logic              r_rd,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_dout,
    output logic              r_valid,
    output logic              ready,
    output logic              addr_err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] w_init_cnt_nxt;

    logic              w_ready;
    logic              w_wr_inrng;
    logic              w_rd_inrng;
    logic              w_wr_ok;
    logic              w_rd_ok;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;
    logic [DATA_W-1:0] w_rd_word;

    logic              r_v1;
    logic [DATA_W-1:0] r_d1;
    logic              r_err;

    assign w_ready    = (r_state == StRun);
    assign w_wr_inrng = ({1'b0, w_addr} < DEPTH_X);
    assign w_rd_inrng = ({1'b0, r_addr} < DEPTH_X);
    // Strobes are dropped entirely while the init sequence is running.
    assign w_wr_ok    = w_wr && w_ready;
    assign w_rd_ok    = r_rd && w_ready;

    // State register and init counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (INIT_ON_RESET) begin
                r_state <= StInit;
            end else begin
                r_state <= StRun;
            end
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Next state and the single array write port, shared by init and user writes.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_mem_we       = 1'b0;
        w_mem_addr     = w_addr;
        w_mem_din      = w_din;
        unique case (r_state)
            StInit: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_init_cnt;
                w_mem_din  = '0;
                if (r_init_cnt == LAST_CNT) begin
                    w_state_nxt    = StRun;
                    w_init_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            StRun: begin
                w_mem_we = w_wr_ok && w_wr_inrng;
            end
        endcase
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Read word selection.
    // An out-of-range address reads as zero.
    // On a same-address collision, BYPASS picks the incoming write data.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_inrng) begin
            w_rd_word = r_mem[r_addr];
            if (BYPASS && w_wr_ok && (w_addr == r_addr)) begin
                w_rd_word = w_din;
            end
        end
    end

    // First read stage plus the address error flag.
    // The data register holds its value when no read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1  <= 1'b0;
            r_d1  <= '0;
            r_err <= 1'b0;
        end else begin
            r_v1 <= w_rd_ok;
            if (w_rd_ok) begin
                r_d1 <= w_rd_word;
            end
            // Both ports out of range on one edge still give a single pulse.
            r_err <= (w_wr_ok && !w_wr_inrng) || (w_rd_ok && !w_rd_inrng);
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic              r_v2;
        logic [DATA_W-1:0] r_d2;

        // Optional second stage: same data and valid, one cycle later.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= r_d1;
                end
            end
        end

        assign r_valid = r_v2;
        assign r_dout  = r_d2;
    end else begin : g_no_out_reg
        assign r_valid = r_v1;
        assign r_dout  = r_d1;
    end

    assign ready    = w_ready;
    assign addr_err = r_err;

endmodule

// File: tb/tb_ram_1r1w_synch_param.sv
// Testbench for ram_1r1w_synch_param.
// Three DUT builds share one stimulus stream:
//   inst 0: DEPTH 8, latency 1, write-first bypass
//   inst 1: DEPTH 8, latency 2, read-old
//   inst 2: DEPTH 6, latency 1, write-first bypass
module tb_ram_1r1w_synch_param;
    localparam int DW = 4;
    localparam int AW = 3;
    localparam int NI = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          w_wr   = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_din  = '0;
    logic          r_rd   = 1'b0;
    logic [AW-1:0] r_addr = '0;

    logic [DW-1:0] o_dout  [NI];
    logic          o_valid [NI];
    logic          o_ready [NI];
    logic          o_err   [NI];

    int dep [NI] = '{8, 8, 6};
    int byp [NI] = '{1, 0, 1};
    int lat [NI] = '{1, 2, 1};

    // Reference model state, per instance.
    logic [DW-1:0] m_mem  [NI][8];
    int            m_init [NI];
    bit            m_cv   [NI];
    bit            m_pv   [NI];
    logic [DW-1:0] m_cd   [NI];
    logic [DW-1:0] m_pd   [NI];
    logic [DW-1:0] m_dout [NI];
    bit            m_v    [NI];
    bit            m_err  [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    ram_1r1w_synch_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .OUT_REG(1'b0), .BYPASS(1'b1), .INIT_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .w_wr(w_wr), .w_addr(w_addr), .w_din(w_din), .r_rd(r_rd),
        .r_addr(r_addr), .r_dout(o_dout[0]), .r_valid(o_valid[0]), .ready(o_ready[0]),
        .addr_err(o_err[0])
    );

    ram_1r1w_synch_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .OUT_REG(1'b1), .BYPASS(1'b0), .INIT_ON_RESET(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .w_wr(w_wr), .w_addr(w_addr), .w_din(w_din), .r_rd(r_rd),
        .r_addr(r_addr), .r_dout(o_dout[1]), .r_valid(o_valid[1]), .ready(o_ready[1]),
        .addr_err(o_err[1])
    );

    ram_1r1w_synch_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(6), .OUT_REG(1'b0), .BYPASS(1'b1), .INIT_ON_RESET(1'b1)
    ) dut_c (
        .clk(clk), .reset(reset), .w_wr(w_wr), .w_addr(w_addr), .w_din(w_din), .r_rd(r_rd),
        .r_addr(r_addr), .r_dout(o_dout[2]), .r_valid(o_valid[2]), .ready(o_ready[2]),
        .addr_err(o_err[2])
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_init[i] = dep[i];
            m_cv[i]   = 1'b0;
            m_pv[i]   = 1'b0;
            m_cd[i]   = '0;
            m_pd[i]   = '0;
            m_dout[i] = '0;
            m_v[i]    = 1'b0;
            m_err[i]  = 1'b0;
        end
    endtask

    // Applies one rising edge to the model, using the current inputs.
    task automatic model_edge();
        int wa;
        int ra;
        wa = int'(w_addr);
        ra = int'(r_addr);
        for (int i = 0; i < NI; i++) begin
            m_pv[i]  = m_cv[i];
            m_pd[i]  = m_cd[i];
            m_cv[i]  = 1'b0;
            m_err[i] = 1'b0;
            if (m_init[i] > 0) begin
                m_mem[i][dep[i] - m_init[i]] = '0;
                m_init[i]--;
            end else begin
                if (r_rd) begin
                    m_cv[i] = 1'b1;
                    if (ra >= dep[i]) begin
                        m_cd[i]  = '0;
                        m_err[i] = 1'b1;
                    end else if (byp[i] != 0 && w_wr && wa == ra) begin
                        m_cd[i] = w_din;
                    end else begin
                        m_cd[i] = m_mem[i][ra];
                    end
                end
                if (w_wr) begin
                    if (wa < dep[i]) begin
                        m_mem[i][wa] = w_din;
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
            end
            m_v[i] = (lat[i] == 1) ? m_cv[i] : m_pv[i];
            if (m_v[i]) begin
                m_dout[i] = (lat[i] == 1) ? m_cd[i] : m_pd[i];
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s inst%0d t=%0t observed=%h expected=%h", tag, i, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("ready", i, {3'b000, o_ready[i]}, {3'b000, m_init[i] == 0});
            chk("r_valid", i, {3'b000, o_valid[i]}, {3'b000, m_v[i]});
            chk("addr_err", i, {3'b000, o_err[i]}, {3'b000, m_err[i]});
            chk("r_dout", i, o_dout[i], m_dout[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_edge();
        end
        #1;
        check_all();
    endtask

    task automatic drive(input int wr, input int wa, input int wd, input int rd, input int ra);
        w_wr   = (wr != 0);
        w_addr = AW'(wa);
        w_din  = DW'(wd);
        r_rd   = (rd != 0);
        r_addr = AW'(ra);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic drive_rand();
        drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        // Power-on reset.
        #2;
        assert_reset();
        idle(2);
        reset = 1'b1;
        // Init phase with strobes present; they must be ignored until ready.
        repeat (8) drive_rand();
        idle(1);

        // Pre-fill with F, leave a read in flight, then reset mid-RUN.
        for (int a = 0; a < 8; a++) drive(1, a, 15, 0, 0);
        drive(0, 0, 0, 1, 5);
        assert_reset();
        idle(1);
        reset = 1'b1;
        idle(8);
        // Every word must read back as zero after init.
        for (int a = 0; a < 8; a++) drive(0, 0, 0, 1, a);
        idle(2);

        // Write then read on the next edge.
        drive(1, 3, 'hA, 0, 0);
        drive(0, 0, 0, 1, 3);
        idle(2);

        // Same-address collision, then a follow-up read.
        drive(1, 2, 9, 0, 0);
        drive(1, 2, 5, 1, 2);
        drive(0, 0, 0, 1, 2);
        idle(2);

        // Out-of-range addresses (only for the depth-6 build).
        drive(1, 7, 3, 0, 0);
        drive(0, 0, 0, 1, 6);
        drive(1, 7, 1, 1, 6);
        drive(0, 0, 0, 1, 7);
        idle(2);

        // Streaming reads after writing data = address.
        for (int a = 0; a < 8; a++) drive(1, a, a, 0, 0);
        for (int a = 0; a < 8; a++) drive(0, 0, 0, 1, a);
        idle(2);

        // Reset after four init cycles; init must restart from address 0.
        assert_reset();
        idle(1);
        reset = 1'b1;
        repeat (4) drive_rand();
        assert_reset();
        idle(1);
        reset = 1'b1;
        repeat (8) drive_rand();
        for (int a = 0; a < 8; a++) drive(0, 0, 0, 1, a);
        idle(2);

        // Random traffic.
        repeat (400) drive_rand();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_synch_param.md
Name: ram_1r1w_synch_param

Overview:
Parametrised single-clock RAM with one write port and one read port, a synchronous read and registered read-valid. It is the storage element behind the queue datapath. Beyond a plain 1R1W array, it adds:
- post-reset zero-initialisation sequencer with a ready flag
- read-enable with valid tracking
- selectable write-first bypass on same-address collisions
- optional output pipeline register
- out-of-range address detection for non-power-of-two depths

Parameters:
DATA_W, 4, word width in bits (>=1)
ADDR_W, 3, address width in bits (>=1)
DEPTH, 8, number of words; 2 <= DEPTH <= 2**ADDR_W
OUT_REG, 0, 1 = extra output register stage (read latency 2), 0 = latency 1
BYPASS, 1, 1 = write-first on same-address collision, 0 = read-old
INIT_ON_RESET, 1, 1 = zero all words after reset release, 0 = no init (contents undefined)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
w_wr  input  1  write strobe
w_addr  input  ADDR_W  write address
w_din  input  DATA_W  write data
r_rd  input  1  read strobe
r_addr  input  ADDR_W  read address
r_dout  output  DATA_W  read data
r_valid  output  1  one-cycle pulse: r_dout carries the data for a completed read
ready  output  1  1 = ports accepted; 0 during init sequence
addr_err  output  1  one-cycle pulse: an accepted strobe used an address >= DEPTH

Behaviour:
- Reset (reset==0, asynchronous): r_dout=0, r_valid=0, addr_err=0, all pipeline regs cleared.
  - INIT_ON_RESET=1: ready=0, init counter=0, FSM=INIT.
  - INIT_ON_RESET=0: ready=1, FSM=RUN.
  - The array itself is not cleared by reset.
- FSM INIT: one word written with 0 per clock at address init_cnt, starting at 0.
  - After writing DEPTH-1, FSM=RUN and ready=1 from the next cycle on.
  - INIT lasts exactly DEPTH cycles after the first edge with reset==1.
  - w_wr and r_rd are ignored (dropped, no addr_err) while ready==0.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset state. With INIT_ON_RESET=1 the init restarts from address 0.
- FSM RUN, write: edge with w_wr=1 and w_addr<DEPTH stores w_din at w_addr. With w_addr>=DEPTH the write is dropped and addr_err=1 for the following cycle.
- FSM RUN, read (OUT_REG=0): edge N with r_rd=1 samples r_addr. After edge N, r_dout = word and r_valid=1 for exactly one cycle.
- OUT_REG=1: same data and r_valid, delayed one more cycle (after edge N+1).
- Back-to-back reads every cycle yield a continuous r_valid=1 stream in request order.
- With no read in flight, r_valid=0 and r_dout holds its last value.
- Read address >= DEPTH: r_dout=0 with r_valid=1 at normal latency; addr_err=1 for the cycle after the request edge.
- A write and a read both out of range on the same edge produce a single addr_err pulse.
- Collision (same edge, w_wr=1, r_rd=1, w_addr==r_addr<DEPTH):
  - BYPASS=1: returned data = w_din.
  - BYPASS=0: returned data = pre-write contents.
  - Either way the write is performed.
- A read issued on the edge after a write to the same address always returns the new data.
- Widths: addresses compared unsigned at full ADDR_W; no wrap-around of out-of-range addresses.

Test Plan:
- DATA_W=4, ADDR_W=3, DEPTH=8, INIT_ON_RESET=1: pre-fill the array with 4'hF via backdoor, then reset -> ready=0 for 8 cycles, ready=1 afterwards; reading addresses 0..7 returns 0 with r_valid pulses at latency 1.
- RUN, write 4'hA to addr 3, then read addr 3 on the next edge -> r_dout=4'hA and r_valid=1 one cycle after the read edge. Repeat with OUT_REG=1 -> same data at latency 2.
- Same-edge write 4'h5 and read of addr 2, which holds 4'h9 -> BYPASS=1 returns 4'h5; BYPASS=0 returns 4'h9; a subsequent read returns 4'h5 in both builds.
- DEPTH=6, ADDR_W=3: write to addr 7 -> addr_err pulse, no store. Read addr 6 -> r_dout=0, r_valid=1, addr_err=1.
- Assert reset at init_cnt=4 -> r_valid=0 and ready=0 immediately; after release init runs a full DEPTH cycles from address 0. Strobes issued during init produce no r_valid and no writes.
- Streaming reads of addr 0..7 on consecutive edges after writing data = address -> r_valid held high 8 cycles, r_dout = 0,1,...,7 in order.
